// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with a persistent NZCV flag register and a one-entry output register.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             Z,
   output logic             N,
   output logic             C,
   output logic             V,
   output logic             busy
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_ADC = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic [WIDTH-1:0] result_q, result_d;
   logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic             load;
   logic [WIDTH-1:0] ld_res;
   logic             ld_c, ld_v;

   logic [WIDTH-1:0] b_eff;
   logic             cin;
   logic [WIDTH:0]   sum_ext;
   logic             add_v;
   logic [WIDTH-1:0] op_res;
   logic             op_c, op_v;

`ifdef ALU_MUL_EN
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [0:0]         state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_next;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   assign in_ready = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
   assign busy     = (state_q == ST_MUL);
`else
   assign in_ready = ~out_valid_q | out_ready;
   assign busy     = 1'b0;
`endif

   assign accept = in_valid & in_ready;

   // One adder serves ADD, SUB, ADC and SLT; ADC takes the carry currently held in the flag register.
   always_comb begin
      b_eff = B;
      cin   = 1'b0;
      case (ALUControl)
         OP_SUB, OP_SLT: begin
            b_eff = ~B;
            cin   = 1'b1;
         end
         OP_ADC: cin = c_q;
         default: ;
      endcase
      sum_ext = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      add_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum_ext[WIDTH-1] != A[WIDTH-1]);
   end

   always_comb begin
      op_res = sum_ext[WIDTH-1:0];
      op_c   = sum_ext[WIDTH];
      op_v   = add_v;
      case (ALUControl)
         OP_AND: begin op_res = A & B; op_c = 1'b0; op_v = 1'b0; end
         OP_OR:  begin op_res = A | B; op_c = 1'b0; op_v = 1'b0; end
         OP_XOR: begin op_res = A ^ B; op_c = 1'b0; op_v = 1'b0; end
         OP_SLT: begin
            op_res    = '0;
            op_res[0] = sum_ext[WIDTH-1] ^ add_v;
         end
         OP_MUL: begin op_res = '0; op_c = 1'b0; op_v = 1'b0; end
         default: ;
      endcase
   end

   // Result and flags load together whenever out_valid is set; otherwise they hold after draining.
   always_comb begin
      result_d    = result_q;
      z_d         = z_q;
      n_d         = n_q;
      c_d         = c_q;
      v_d         = v_q;
      out_valid_d = out_valid_q & ~out_ready;
      load        = 1'b0;
      ld_res      = op_res;
      ld_c        = op_c;
      ld_v        = op_v;
`ifdef ALU_MUL_EN
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
      if (accept && (ALUControl == OP_MUL)) begin
         state_d  = ST_MUL;
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, A};
         mplier_d = B;
         cnt_d    = '0;
      end else if (accept) begin
         load = 1'b1;
      end else if (state_q == ST_MUL) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            load    = 1'b1;
            ld_res  = acc_next[WIDTH-1:0];
            ld_c    = |acc_next[2*WIDTH-1:WIDTH];
            ld_v    = 1'b0;
         end
      end
`else
      load = accept;
`endif
      if (load) begin
         result_d    = ld_res;
         z_d         = (ld_res == '0);
         n_d         = ld_res[WIDTH-1];
         c_d         = ld_c;
         v_d         = ld_v;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q    <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         z_q         <= z_d;
         n_q         <= n_d;
         c_q         <= c_d;
         v_q         <= v_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef ALU_MUL_EN
   // Reset aborts a multiply in flight; the partial accumulator is simply discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end
`endif

   assign result    = result_q;
   assign Z         = z_q;
   assign N         = n_q;
   assign C         = c_q;
   assign V         = v_q;
   assign out_valid = out_valid_q;

endmodule
